inst_fetch_unit: RTL and testbench

Instruction fetch unit for the 16-bit MSP430-style core. It owns the program counter, fetches words from instruction memory over a request/acknowledge handshake, and presents the fetched instruction and extension word to `control_unit`. It serves `control_unit`'s `pc_inc` / `en_pc_2` / `branch_en` / `pc_offset` outputs and drives its `instruction` input.

---
 rtl/cpu_defs.sv | 24 ++
 rtl/branch_target.sv | 12 +
 rtl/inst_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the MSP430-style core: word/offset widths, fetch FSM
// state encoding, fetch target encoding and the PC-relative offset helper.
package cpu_defs;

  localparam int WORD_W   = 16;
  localparam int OFFSET_W = 10;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_IDLE  = 2'd2
  } fetch_state_e;

  typedef enum logic {
    TGT_INSTR = 1'b0,
    TGT_EXT   = 1'b1
  } fetch_target_e;

  // Signed word offset converted to a byte displacement (sign-extended, x2).
  function automatic logic [WORD_W-1:0] offset_to_bytes(input logic [OFFSET_W-1:0] off);
    return {{(WORD_W-OFFSET_W-1){off[OFFSET_W-1]}}, off, 1'b0};
  endfunction

endpackage

// File: rtl/branch_target.sv
// PC-relative target: pc + sign_extend(offset) * 2, wrapping modulo 2^16.
module branch_target
  import cpu_defs::*;
(
  input  logic [WORD_W-1:0]   pc,
  input  logic [OFFSET_W-1:0] pc_offset,
  output logic [WORD_W-1:0]   target
);

  assign target = pc + offset_to_bytes(pc_offset);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches instruction/extension words over
// a request/acknowledge memory port and reports sticky fetch timeouts.
//
// Memory handshake: mem_rd rises with mem_addr valid and both stay constant until
// the cycle in which mem_ack=1 is sampled on a rising edge (mem_data is captured at
// that same edge) or until the timeout aborts the request; mem_ack is ignored
// whenever mem_rd is low.
module inst_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_inc,
  input  logic                en_pc_2,
  input  logic                branch_en,
  input  logic [OFFSET_W-1:0] pc_offset,
  output logic [WORD_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [WORD_W-1:0]   mem_data,
  input  logic                mem_ack,
  output logic [WORD_W-1:0]   instruction,
  output logic [WORD_W-1:0]   ext_word,
  output logic                inst_valid,
  output logic [WORD_W-1:0]   pc,
  output logic                busy,
  output logic                fetch_err,
  output logic [1:0]          dbg_state
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_e  state_q, state_d;
  fetch_target_e tgt_q, tgt_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] ext_q, ext_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [7:0]        wait_q, wait_d;
  logic [WORD_W-1:0] jump_addr;

  branch_target u_branch_target (
    .pc        (pc_q),
    .pc_offset (pc_offset),
    .target    (jump_addr)
  );

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    instr_d    = instr_q;
    ext_d      = ext_q;
    valid_d    = valid_q;
    err_d      = err_q;
    wait_d     = wait_q;

    case (state_q)
      ST_BOOT: begin
        state_d    = ST_FETCH;
        tgt_d      = TGT_INSTR;
        mem_addr_d = pc_q;
        mem_rd_d   = 1'b1;
        valid_d    = 1'b0;
        wait_d     = 8'd0;
      end

      ST_FETCH: begin
        if (mem_ack) begin
          if (tgt_q == TGT_INSTR) begin
            instr_d = mem_data;
            valid_d = 1'b1;
          end else begin
            ext_d = mem_data;
          end
          // mem_addr_q still holds the address of the word just fetched.
          pc_d     = mem_addr_q + 16'd2;
          mem_rd_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          err_d    = 1'b1;
          mem_rd_d = 1'b0;
          valid_d  = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_IDLE: begin
        if (pc_inc) begin
          state_d  = ST_FETCH;
          mem_rd_d = 1'b1;
          wait_d   = 8'd0;
          if (branch_en) begin
            mem_addr_d = jump_addr;
            tgt_d      = TGT_INSTR;
            valid_d    = 1'b0;
          end else if (en_pc_2) begin
            mem_addr_d = pc_q;
            tgt_d      = TGT_EXT;
          end else begin
            mem_addr_d = pc_q;
            tgt_d      = TGT_INSTR;
            valid_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d  = ST_BOOT;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      tgt_q      <= TGT_INSTR;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_rd_q   <= 1'b0;
      instr_q    <= '0;
      ext_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      instr_q    <= instr_d;
      ext_q      <= ext_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign instruction = instr_q;
  assign ext_word    = ext_q;
  assign inst_valid  = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q != ST_IDLE);
  assign fetch_err   = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized fetch sequences
// checked against a transaction-level model of PC, instruction and extension word.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_inc = 1'b0, en_pc_2 = 1'b0, branch_en = 1'b0;
  logic [9:0]  pc_offset = '0;
  logic [15:0] mem_addr, mem_data = '0;
  logic        mem_rd, mem_ack = 1'b0;
  logic [15:0] instruction, ext_word, pc;
  logic        inst_valid, busy, fetch_err;
  logic [1:0]  dbg_state;

  // Second instance with a wrapping reset PC.
  logic        w_rst = 1'b1;
  logic        w_pc_inc = 1'b0, w_branch_en = 1'b0;
  logic [9:0]  w_pc_offset = '0;
  logic [15:0] w_mem_addr, w_mem_data = '0;
  logic        w_mem_rd, w_mem_ack = 1'b0;
  logic [15:0] w_instruction, w_ext_word, w_pc;
  logic        w_inst_valid, w_busy, w_fetch_err;
  logic [1:0]  w_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_pc = 16'h0000, m_instr = '0, m_ext = '0;
  logic        m_valid = 1'b0, m_err = 1'b0;

  inst_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .pc_inc(pc_inc), .en_pc_2(en_pc_2), .branch_en(branch_en),
    .pc_offset(pc_offset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ack(mem_ack), .instruction(instruction), .ext_word(ext_word),
    .inst_valid(inst_valid), .pc(pc), .busy(busy), .fetch_err(fetch_err),
    .dbg_state(dbg_state)
  );

  inst_fetch_unit #(.RESET_PC(16'hFFFE), .TIMEOUT(15)) dut_w (
    .clk(clk), .rst(w_rst), .pc_inc(w_pc_inc), .en_pc_2(1'b0), .branch_en(w_branch_en),
    .pc_offset(w_pc_offset), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd), .mem_data(w_mem_data),
    .mem_ack(w_mem_ack), .instruction(w_instruction), .ext_word(w_ext_word),
    .inst_valid(w_inst_valid), .pc(w_pc), .busy(w_busy), .fetch_err(w_fetch_err),
    .dbg_state(w_dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Jump target from the arithmetic definition: signed word offset, byte address, mod 2^16.
  function automatic logic [15:0] model_target(input logic [15:0] p, input logic [9:0] off);
    int o;
    o = int'(off);
    if (o >= 512) o = o - 1024;
    return 16'(int'(p) + 2 * o);
  endfunction

  // Driver: present a one-cycle pc_inc request (kind 0 seq, 1 ext, 2 branch, 3 branch+ext).
  task automatic issue(input int kind, input logic [9:0] off);
    pc_inc = 1'b1;
    en_pc_2 = (kind == 1 || kind == 3);
    branch_en = (kind >= 2);
    pc_offset = off;
    @(negedge clk);
    pc_inc = 1'b0; en_pc_2 = 1'b0; branch_en = 1'b0;
  endtask

  // Driver: memory responds after k wait cycles; reports observed request behaviour.
  task automatic serve(input int k, input logic [15:0] data, output int rd_cycles,
                       output logic [15:0] addr0, output logic stable);
    rd_cycles = 0; addr0 = mem_addr; stable = 1'b1;
    for (int i = 0; i <= k; i++) begin
      if (mem_rd) rd_cycles++;
      if (mem_addr !== addr0) stable = 1'b0;
      if (i == k) begin mem_ack = 1'b1; mem_data = data; end
      @(negedge clk);
    end
    mem_ack = 1'b0; mem_data = 16'($urandom);
  endtask

  // Model update for a completed fetch.
  task automatic model_ack(input logic [15:0] addr, input logic is_ext, input logic [15:0] data);
    if (is_ext) m_ext = data;
    else begin m_instr = data; m_valid = 1'b1; end
    m_pc = addr + 16'd2;
  endtask

  // Compares all architecturally visible outputs against the model.
  task automatic check_state(input string name);
    n_checks++;
    if (instruction !== m_instr || ext_word !== m_ext || inst_valid !== m_valid ||
        pc !== m_pc || fetch_err !== m_err || busy !== 1'b0 || mem_rd !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: got instr=%h ext=%h valid=%b pc=%h err=%b busy=%b rd=%b, expected instr=%h ext=%h valid=%b pc=%h err=%b busy=0 rd=0",
               name, instruction, ext_word, inst_valid, pc, fetch_err, busy, mem_rd,
               m_instr, m_ext, m_valid, m_pc, m_err);
    end
  endtask

  // Full transaction: issue, check request, serve, check result.
  task automatic fetch_txn(input string name, input int kind, input logic [9:0] off,
                           input int k, input logic [15:0] data);
    logic [15:0] exp_addr, addr0;
    logic        is_ext, exp_valid_in, stable;
    int          rd_cycles;
    is_ext   = (kind == 1);
    exp_addr = (kind >= 2) ? model_target(m_pc, off) : m_pc;
    exp_valid_in = is_ext ? m_valid : 1'b0;
    issue(kind, off);
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== exp_addr || busy !== 1'b1 || inst_valid !== exp_valid_in) begin
      n_errors++;
      $display("FAIL %s_req: got rd=%b addr=%h busy=%b valid=%b, expected rd=1 addr=%h busy=1 valid=%b",
               name, mem_rd, mem_addr, busy, inst_valid, exp_addr, exp_valid_in);
    end
    serve(k, data, rd_cycles, addr0, stable);
    n_checks++;
    if (rd_cycles != k + 1 || stable !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_hold: got rd_cycles=%0d stable=%b, expected rd_cycles=%0d stable=1",
               name, rd_cycles, stable, k + 1);
    end
    model_ack(exp_addr, is_ext, data);
    check_state({name, "_done"});
  endtask

  task automatic test_reset();
    logic [15:0] addr0;
    logic        stable;
    int          rd_cycles;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pc !== 16'h0000 || mem_addr !== 16'h0000 || mem_rd !== 1'b0 || instruction !== 16'h0000 ||
        ext_word !== 16'h0000 || inst_valid !== 1'b0 || fetch_err !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_values: got pc=%h addr=%h rd=%b instr=%h ext=%h valid=%b err=%b busy=%b",
               pc, mem_addr, mem_rd, instruction, ext_word, inst_valid, fetch_err, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      n_errors++;
      $display("FAIL boot_request: got rd=%b addr=%h, expected rd=1 addr=0000", mem_rd, mem_addr);
    end
    serve(0, 16'h4A0B, rd_cycles, addr0, stable);
    n_checks++;
    if (rd_cycles != 1) begin
      n_errors++;
      $display("FAIL boot_rd_cycles: got %0d, expected 1", rd_cycles);
    end
    model_ack(16'h0000, 1'b0, 16'h4A0B);
    check_state("boot_fetch");
  endtask

  task automatic test_ext_word();
    fetch_txn("ext_wait3", 1, 10'h000, 3, 16'h1234);
  endtask

  task automatic test_branch_back();
    while (m_pc != 16'h0010) fetch_txn("seq_walk", 0, 10'h000, 0, 16'($urandom));
    fetch_txn("branch_m1", 2, 10'h3FF, 1, 16'hC0DE);
    fetch_txn("branch_prio", 3, 10'h004, 0, 16'h7777);
  endtask

  task automatic test_ack_idle();
    repeat (2) begin
      mem_ack = 1'b1; mem_data = 16'hDEAD;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check_state("ack_in_idle");
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    pc_inc = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      mem_data = d;
      @(negedge clk);
      if (i % 2 == 1) model_ack(m_pc, 1'b0, d);
    end
    pc_inc = 1'b0; mem_ack = 1'b0;
    check_state("back_to_back");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++)
      fetch_txn("random", $urandom_range(0, 3), 10'($urandom_range(0, 1023)),
                $urandom_range(0, 6), 16'($urandom));
  endtask

  task automatic test_timeout();
    int n;
    issue(0, 10'h000);
    n = 0;
    while (mem_rd === 1'b1 && n < 40) begin
      n++;
      pc_inc = (n == 3);
      @(negedge clk);
      pc_inc = 1'b0;
    end
    n_checks++;
    if (n != 15) begin
      n_errors++;
      $display("FAIL timeout_len: got mem_rd high %0d cycles, expected 15", n);
    end
    m_err = 1'b1; m_valid = 1'b0;
    check_state("timeout_result");
    repeat (3) @(negedge clk);
    check_state("timeout_no_queue");
  endtask

  task automatic test_reset_mid_fetch();
    logic [15:0] addr0;
    logic        stable;
    int          rd_cycles;
    issue(0, 10'h000);
    @(negedge clk);
    mem_ack = 1'b1; mem_data = 16'hBEEF;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_rd !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async_rd: got rd=%b, expected 0", mem_rd);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    m_pc = 16'h0000; m_instr = '0; m_ext = '0; m_valid = 1'b0; m_err = 1'b0;
    n_checks++;
    if (pc !== m_pc || mem_addr !== 16'h0000 || instruction !== m_instr || ext_word !== m_ext ||
        inst_valid !== m_valid || fetch_err !== m_err || busy !== 1'b1 || mem_rd !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_values: got pc=%h addr=%h instr=%h ext=%h valid=%b err=%b busy=%b rd=%b",
               pc, mem_addr, instruction, ext_word, inst_valid, fetch_err, busy, mem_rd);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      n_errors++;
      $display("FAIL rst_refetch: got rd=%b addr=%h, expected rd=1 addr=0000", mem_rd, mem_addr);
    end
    serve(0, 16'h55AA, rd_cycles, addr0, stable);
    model_ack(16'h0000, 1'b0, 16'h55AA);
    check_state("rst_refetch_done");
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc;
    logic [15:0] exp_addr;
    logic [9:0]  offs [2];
    offs[0] = 10'h37F; offs[1] = 10'h1FF;
    w_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_mem_rd !== 1'b1 || w_mem_addr !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL wrap_boot_req: got rd=%b addr=%h, expected rd=1 addr=fffe", w_mem_rd, w_mem_addr);
    end
    w_mem_ack = 1'b1; w_mem_data = 16'h1111;
    @(negedge clk);
    w_mem_ack = 1'b0;
    exp_pc = 16'h0000;
    n_checks++;
    if (w_pc !== exp_pc || w_instruction !== 16'h1111) begin
      n_errors++;
      $display("FAIL wrap_pc: got pc=%h instr=%h, expected pc=0000 instr=1111", w_pc, w_instruction);
    end
    for (int i = 0; i < 2; i++) begin
      exp_addr = model_target(exp_pc, offs[i]);
      w_pc_inc = 1'b1; w_branch_en = 1'b1; w_pc_offset = offs[i];
      @(negedge clk);
      w_pc_inc = 1'b0; w_branch_en = 1'b0;
      n_checks++;
      if (w_mem_rd !== 1'b1 || w_mem_addr !== exp_addr) begin
        n_errors++;
        $display("FAIL wrap_branch_addr: got rd=%b addr=%h, expected rd=1 addr=%h", w_mem_rd, w_mem_addr, exp_addr);
      end
      w_mem_ack = 1'b1; w_mem_data = 16'(i);
      @(negedge clk);
      w_mem_ack = 1'b0;
      exp_pc = exp_addr + 16'd2;
    end
    n_checks++;
    if (w_mem_addr !== 16'h02FE || w_pc !== 16'h0300) begin
      n_errors++;
      $display("FAIL wrap_final: got addr=%h pc=%h, expected addr=02fe pc=0300", w_mem_addr, w_pc);
    end
  endtask

  initial begin
    test_reset();
    test_ext_word();
    test_branch_back();
    test_ack_idle();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_fetch();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
